// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART transmitter blocks.
// Parity selectors and the transmit FSM state encoding.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: small synchronous FIFO holding bytes waiting to be sent.
// A write into a full FIFO is taken only when the head leaves that cycle.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push;
    logic             pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0])
                  && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Qualify pop/push and advance the wrapping pointers.
    always_comb begin
        pop      = pop_i & ~empty_o;
        push     = wr_i & (~full_o | pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, written at the tail slot.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with tick divider.
// Frames are start, LSB-first data, optional parity, then stop bits.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk_master,
    input  logic                 rst_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 data_we_i,
    input  logic                 tx_en,
    output logic                 tx_o,
    output logic                 tx_done,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 busy_o,
    output logic                 overflow_o
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int TW = $clog2(STOP_BITS * OVERSAMPLE + 1);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BITS * OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    logic [DW-1:0]        div_q, div_d;
    logic                 tick;
    tx_state_e            state_q, state_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;
    logic                 pop;
    logic                 bit_end;
    logic                 stop_end;
    logic [DATA_BITS-1:0] head;
    logic                 fifo_full;
    logic                 fifo_empty;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_master),
        .rst_n   (rst_i),
        .wr_i    (data_we_i),
        .wdata_i (data_i),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign tx_o       = tx_q;
    assign tx_done    = done_q;
    assign full_o     = fifo_full;
    assign empty_o    = fifo_empty;
    assign busy_o     = (state_q != ST_IDLE);
    assign overflow_o = ovf_q;

    // Free-running divider producing a one-cycle tick.
    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + DW'(1);
    end

    // Frame sequencing: bit timing, data shifting and frame chaining.
    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        bcnt_d   = bcnt_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        pop      = 1'b0;
        bit_end  = tick && (tcnt_q == BIT_LAST);
        stop_end = tick && (tcnt_q == STOP_LAST);
        if (tick) begin
            tcnt_d = tcnt_q + TW'(1);
        end
        unique case (state_q)
            ST_IDLE: begin
                tcnt_d = '0;
                pop    = tick && tx_en && !fifo_empty;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    tcnt_d  = '0;
                    bcnt_d  = '0;
                    tx_d    = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    tcnt_d = '0;
                    if (bcnt_q == DATA_LAST) begin
                        if (PARITY != PAR_NONE) begin
                            state_d = ST_PAR;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bcnt_d  = bcnt_q + BW'(1);
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end
            end
            ST_PAR: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    tcnt_d  = '0;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (stop_end) begin
                    done_d  = 1'b1;
                    tcnt_d  = '0;
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                    pop     = tx_en && !fifo_empty;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        if (pop) begin
            state_d = ST_START;
            tcnt_d  = '0;
            tx_d    = 1'b0;
            shreg_d = head;
            par_d   = (^head) ^ (PARITY == PAR_ODD);
        end
        ovf_d = ovf_q | (data_we_i & fifo_full & ~pop);
    end

    // Tick divider register.
    always_ff @(posedge clk_master or negedge rst_i) begin
        if (!rst_i) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // FSM and registered line outputs.
    always_ff @(posedge clk_master or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench with a tick-position line model.
// Default instance is checked every cycle; parity instances by sampling.
module tb_uart_tx_fifo;

    localparam int CD    = 8;
    localparam int OS    = 16;
    localparam int DEPTH = 4;
    localparam int LT    = 10 * OS;

    logic       clk;
    logic       rst_n;
    logic [7:0] din0;
    logic       we0;
    logic       en0;
    logic [6:0] dinp;
    logic       wep;
    logic       enp;
    logic [2:0] tx_w, done_w, full_w, empty_w, busy_w, ovf_w;

    int checks   = 0;
    int failures = 0;

    uart_tx_fifo u0 (
        .clk_master (clk),
        .rst_i      (rst_n),
        .data_i     (din0),
        .data_we_i  (we0),
        .tx_en      (en0),
        .tx_o       (tx_w[0]),
        .tx_done    (done_w[0]),
        .full_o     (full_w[0]),
        .empty_o    (empty_w[0]),
        .busy_o     (busy_w[0]),
        .overflow_o (ovf_w[0])
    );

    uart_tx_fifo #(
        .DATA_BITS (7),
        .PARITY    (1),
        .STOP_BITS (2)
    ) u1 (
        .clk_master (clk),
        .rst_i      (rst_n),
        .data_i     (dinp),
        .data_we_i  (wep),
        .tx_en      (enp),
        .tx_o       (tx_w[1]),
        .tx_done    (done_w[1]),
        .full_o     (full_w[1]),
        .empty_o    (empty_w[1]),
        .busy_o     (busy_w[1]),
        .overflow_o (ovf_w[1])
    );

    uart_tx_fifo #(
        .DATA_BITS (7),
        .PARITY    (2),
        .STOP_BITS (2)
    ) u2 (
        .clk_master (clk),
        .rst_i      (rst_n),
        .data_i     (dinp),
        .data_we_i  (wep),
        .tx_en      (enp),
        .tx_o       (tx_w[2]),
        .tx_done    (done_w[2]),
        .full_o     (full_w[2]),
        .empty_o    (empty_w[2]),
        .busy_o     (busy_w[2]),
        .overflow_o (ovf_w[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Line model of the default instance: a queue of bytes and a
    // frame described as a bit-slot vector indexed by tick position.
    int          m_div;
    bit          m_act;
    int          m_t;
    logic [15:0] m_bits;
    bit          m_tx;
    bit          m_done;
    bit          m_ovf;
    logic [7:0]  m_q[$];
    bit          m_tick;
    bit          m_pop;
    int          m_pre;

    function automatic logic [15:0] frame_of(input logic [7:0] b);
        logic [15:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
        return f;
    endfunction

    task automatic m_reset();
        m_div  = 0;
        m_act  = 0;
        m_t    = 0;
        m_bits = '1;
        m_tx   = 1;
        m_done = 0;
        m_ovf  = 0;
        m_q.delete();
    endtask

    task automatic m_step();
        m_tick = (m_div == CD - 1);
        m_div  = (m_div + 1) % CD;
        m_pre  = m_q.size();
        m_pop  = 0;
        m_done = 0;
        if (m_tick && m_act) begin
            if (m_t == LT - 1) begin
                m_done = 1;
                m_act  = 0;
                m_tx   = 1;
            end else begin
                m_t  = m_t + 1;
                m_tx = m_bits[m_t / OS];
            end
        end
        if (m_tick && !m_act && en0 && m_pre > 0) begin
            m_bits = frame_of(m_q.pop_front());
            m_t    = 0;
            m_act  = 1;
            m_tx   = m_bits[0];
            m_pop  = 1;
        end
        if (we0) begin
            if (m_pre < DEPTH || m_pop) m_q.push_back(din0);
            else m_ovf = 1;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    logic [5:0] c_act, c_exp;

    // Every-cycle comparison of the default instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            c_act = {tx_w[0], done_w[0], busy_w[0],
                     empty_w[0], full_w[0], ovf_w[0]};
            c_exp = {m_tx, m_done, m_act, m_q.size() == 0,
                     m_q.size() == DEPTH, m_ovf};
            checks++;
            if (c_act !== c_exp) begin
                failures++;
                $display("FAIL model t=%0t tx/done/busy/empty/full/ovf actual=%b required=%b",
                         $time, c_act, c_exp);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic write0(input logic [7:0] b);
        @(posedge clk); #1;
        din0 = b;
        we0  = 1'b1;
        @(posedge clk); #1;
        we0  = 1'b0;
    endtask

    task automatic wait_for(input int sel, input bit want_done,
                            input int max, output time t);
        bit hit;
        hit = 0;
        t   = $time;
        for (int i = 0; i < max && !hit; i++) begin
            @(negedge clk);
            if (want_done ? done_w[sel] : !tx_w[sel]) begin
                hit = 1;
                t   = $time;
            end
        end
        if (want_done) chk($sformatf("wait_done%0d", sel), int'(hit), 1);
        else chk($sformatf("wait_start%0d", sel), int'(hit), 1);
    endtask

    time         ts, td;
    logic [10:0] pe, po;
    logic [9:0]  e33;
    int          lows, dn;

    initial begin
        rst_n = 1'b0;
        din0  = '0;
        we0   = 1'b0;
        en0   = 1'b0;
        dinp  = '0;
        wep   = 1'b0;
        enp   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", tx_w[0], 1);
        chk("rst_done", done_w[0], 0);
        chk("rst_empty", empty_w[0], 1);
        chk("rst_full", full_w[0], 0);
        chk("rst_busy", busy_w[0], 0);
        chk("rst_ovf", ovf_w[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 7-bit data, even and odd parity, two stop bits, byte 0x2D.
        pe = 11'b11001011010;
        po = 11'b11101011010;
        @(posedge clk); #1;
        dinp = 7'h2D;
        wep  = 1'b1;
        enp  = 1'b1;
        @(posedge clk); #1;
        wep  = 1'b0;
        wait_for(1, 0, 400, ts);
        repeat (64) @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            chk($sformatf("even_slot%0d", k), tx_w[1], pe[k]);
            chk($sformatf("odd_slot%0d", k), tx_w[2], po[k]);
            if (k < 10) repeat (128) @(negedge clk);
        end
        wait_for(1, 1, 400, td);
        chk("par_frame_clocks", int'((td - ts) / 10), 1408);
        chk("odd_done_same", done_w[2], 1);
        @(posedge clk); #1;
        enp = 1'b0;

        // Default 8N1 frame for 0xDA.
        e33 = 10'b1110110100;
        @(posedge clk); #1;
        en0 = 1'b1;
        write0(8'hDA);
        wait_for(0, 0, 200, ts);
        repeat (64) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("da_slot%0d", k), tx_w[0], e33[k]);
            if (k < 9) repeat (128) @(negedge clk);
        end
        wait_for(0, 1, 400, td);
        chk("da_frame_clocks", int'((td - ts) / 10), 1280);

        // Fill past capacity with transmission disabled, then drain.
        @(posedge clk); #1;
        en0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            write0(8'(8'h11 * (i + 1)));
            @(negedge clk);
            chk($sformatf("fill%0d_full", i), full_w[0], int'(i >= 3));
            chk($sformatf("fill%0d_ovf", i), ovf_w[0], int'(i >= 4));
        end
        @(posedge clk); #1;
        en0 = 1'b1;
        wait_for(0, 0, 200, ts);
        for (int n = 0; n < 4; n++) begin
            wait_for(0, 1, 1400, td);
        end
        chk("burst_clocks", int'((td - ts) / 10), 4 * 1280);
        chk("burst_empty", empty_w[0], 1);
        chk("burst_busy", busy_w[0], 0);
        chk("burst_ovf_sticky", ovf_w[0], 1);

        // Drop tx_en during data bit 3 with a second byte queued.
        write0(8'hA5);
        write0(8'h3C);
        wait_for(0, 0, 200, ts);
        repeat (570) @(posedge clk); #1;
        en0 = 1'b0;
        wait_for(0, 1, 1000, td);
        chk("drop_frame_clocks", int'((td - ts) / 10), 1280);
        lows = 0;
        dn   = 0;
        repeat (300) begin
            @(negedge clk);
            if (!tx_w[0]) lows++;
            if (done_w[0]) dn++;
        end
        chk("drop_line_low", lows, 0);
        chk("drop_extra_done", dn, 0);
        chk("drop_empty", empty_w[0], 0);
        chk("drop_full", full_w[0], 0);
        chk("drop_busy", busy_w[0], 0);

        // Reset in the middle of data bit 0 of 0x3C.
        write0(8'h77);
        @(posedge clk); #1;
        en0 = 1'b1;
        wait_for(0, 0, 200, ts);
        repeat (200) @(posedge clk); #1;
        chk("pre_rst_tx", tx_w[0], 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", tx_w[0], 1);
        chk("rst_mid_empty", empty_w[0], 1);
        chk("rst_mid_busy", busy_w[0], 0);
        chk("rst_mid_done", done_w[0], 0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        lows = 0;
        dn   = 0;
        repeat (2000) begin
            @(negedge clk);
            if (!tx_w[0]) lows++;
            if (done_w[0]) dn++;
        end
        chk("post_rst_line_low", lows, 0);
        chk("post_rst_done", dn, 0);
        write0(8'h5A);
        wait_for(0, 0, 200, ts);
        wait_for(0, 1, 1400, td);
        chk("post_rst_frame_clocks", int'((td - ts) / 10), 1280);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: frame data bits, legal 5..9.
REQ-002 SHALL have parameter PARITY, default 0: 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter STOP_BITS, default 1: stop bits, legal 1 or 2.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: TX FIFO entries, power of 2, at least 2.
REQ-005 SHALL have parameter CLK_DIV, default 8: clk_master cycles per tick, at least 2.
REQ-006 SHALL have parameter OVERSAMPLE, default 16: ticks per bit.
REQ-007 SHALL have port clk_master, input, 1 bit: single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port data_i, input, DATA_BITS bits: byte to queue.
REQ-010 SHALL have port data_we_i, input, 1 bit: write strobe, one entry per high cycle.
REQ-011 SHALL have port tx_en, input, 1 bit: permits new frames to start.
REQ-012 SHALL have port tx_o, output, 1 bit: serial line, registered, idle high.
REQ-013 SHALL have port tx_done, output, 1 bit: one-cycle pulse at end of last stop bit.
REQ-014 SHALL have ports full_o, empty_o, busy_o, overflow_o, output, 1 bit each: FIFO full; FIFO empty; FSM not IDLE; sticky dropped write.

Function
REQ-015 SHALL run a free-running divider counting 0..CLK_DIV-1 and assert internal tick for one cycle at CLK_DIV-1.
REQ-016 SHALL store data_i when data_we_i=1 and full_o=0, or when data_we_i=1, full_o=1 and a pop occurs in the same cycle.
REQ-017 SHALL drop a write when full_o=1 with no same-cycle pop, and set overflow_o until reset.
REQ-018 SHALL not pop when empty_o=1; a same-cycle write to an empty FIFO starts a frame no earlier than the next tick.
REQ-019 SHALL implement FSM states IDLE, START, DATA, PAR, STOP.
REQ-020 SHALL, in IDLE with tick=1, tx_en=1 and empty_o=0, pop the FIFO head, enter START and drive tx_o=0 on that edge.
REQ-021 SHALL hold START, each DATA bit and PAR for exactly OVERSAMPLE ticks, and STOP for STOP_BITS*OVERSAMPLE ticks.
REQ-022 SHALL send DATA bits LSB first.
REQ-023 SHALL skip PAR when PARITY=0; otherwise the PAR bit SHALL be the XOR of the data bits for even parity, and its inverse for odd parity.
REQ-024 SHALL, at the end of STOP, pulse tx_done and, if tx_en=1 and empty_o=0, pop and enter START on the same edge (no idle gap); otherwise it SHALL enter IDLE.
REQ-025 SHALL complete a frame already in progress when tx_en deasserts, and SHALL start no further frame.
REQ-026 SHALL make frame length (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*OVERSAMPLE*CLK_DIV clocks; the default 8N1 frame is 1280 clocks.
REQ-027 SHALL leave data_we_i and FIFO writes unaffected by tx_en.

Reset
REQ-028 SHALL, on rst_i low, immediately force tx_o=1, tx_done=0, busy_o=0, overflow_o=0, empty_o=1, full_o=0, FSM to IDLE, and divider and bit counters to 0.
REQ-029 SHALL abort a frame cut by reset with no completion pulse, discard FIFO contents, and start nothing after release until a new write.

Structure
REQ-030 SHALL take from shared package uart_pkg: the parity constants (PAR_NONE/EVEN/ODD) and the FSM state encoding.
REQ-031 SHALL instantiate the FIFO as sub-module uart_fifo (parameters WIDTH, DEPTH; write/pop/full/empty); the divider and FSM SHALL be inline.

Verification
REQ-032 Reset: rst_i=0 -> tx_o=1, tx_done=0, empty_o=1, full_o=0, busy_o=0, overflow_o=0.
REQ-033 Defaults, write 0xDA, tx_en=1 -> tx_o bits 0,0,1,0,1,1,0,1,1,1, each 128 clocks; tx_done pulses 1280 clocks after the start edge.
REQ-034 DATA_BITS=7, PARITY=1, write 0x2D -> PAR bit 0; with PARITY=2 -> PAR bit 1; frame 1408 clocks.
REQ-035 FIFO_DEPTH=4, tx_en=0, write 5 bytes -> full_o after the 4th, 5th dropped, overflow_o=1; tx_en=1 -> 4 back-to-back frames with no high gap beyond stop bits; empty_o after the 4th pop.
REQ-036 tx_en dropped during DATA bit 3 with 2 queued -> current frame completes with tx_done; tx_o stays 1; one entry remains.
REQ-037 rst_i low mid-DATA -> tx_o=1 within the same cycle, FIFO empty, no tx_done; after release, line idle until a new write.
